// File: rtl/mem_responder.sv
// Word-addressed on-chip memory answering the CPU's multicycle read/write port.
// Latency: request sampled in cycle 0 -> mem_resp pulse in cycle LATENCY; one access in flight.
// Backpressure: initiator holds its request until mem_resp; dropping it early aborts without access.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   mem_read/write   request strobes (both high is handled as a write)
//   mem_byte_enable  write lane enables, bit i covers mem_wdata[8i+7:8i]
//   mem_address      byte address, word index taken from [ADDR_WIDTH+1:2]
//   mem_wdata        write data
//   mem_rdata        registered read data, held until the next read completes
//   mem_resp         one-cycle completion pulse
//   mem_err          (MEM_RESPONDER_ERR_EN only) flags out-of-range or read+write accesses
//
// Optional feature macro: MEM_RESPONDER_ERR_EN
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic        mem_err
`endif
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  op_write_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  err_q;

  logic                  req;
  logic                  start;
  logic                  do_access;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_err;
  logic                  acc_write;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  acc_err;

  logic [31:0]           mem_array [DEPTH];

  assign req     = mem_read | mem_write;
  assign req_idx = mem_address[ADDR_WIDTH+1:2];

  // Byte offset bits never select anything; byte lanes do that job.
  logic unused_byte_offset;
  assign unused_byte_offset = &{1'b0, mem_address[1:0]};

`ifdef MEM_RESPONDER_ERR_EN
  assign req_err = (|mem_address[31:ADDR_WIDTH+2]) | (mem_read & mem_write);
`else
  // Upper address bits are dropped so addresses alias by wrap-around.
  assign req_err = 1'b0;
  logic unused_high_addr;
  assign unused_high_addr = &{1'b0, mem_address[31:ADDR_WIDTH+2]};
`endif

  // With LATENCY=1 the access happens on the same edge the request is
  // accepted, before the op/index registers are loaded, so use live inputs.
  assign acc_write = start ? mem_write : op_write_q;
  assign acc_idx   = start ? req_idx   : idx_q;
  assign acc_err   = start ? req_err   : err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          start   = 1'b1;
          cnt_nxt = CNT_LOAD;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          // WAIT lasts LATENCY-1 cycles: leave on the edge the count reaches zero.
          if (cnt == 4'd1) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        op_write_q <= mem_write;
        idx_q      <= req_idx;
        err_q      <= req_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= 32'h0;
    end else if (do_access && !acc_write) begin
      mem_rdata <= acc_err ? 32'h0 : mem_array[acc_idx];
    end
  end

  // Array is not reset; the rst_n gate stops a write landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byte_enable[i]) begin
          mem_array[acc_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_resp = (state == RESP);

`ifdef MEM_RESPONDER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= do_access & acc_err;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (ADDR_WIDTH=8, LATENCY=3).
// Expected read data comes from a local byte-lane model and constants, queued at issue time.
// Each scenario task compares its own observations inline.
module tb_mem_responder;

  localparam int AW = 8;
  localparam int L  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = 4'h0;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
`ifdef MEM_RESPONDER_ERR_EN
  logic        mem_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model [256];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
`ifdef MEM_RESPONDER_ERR_EN
    ,
    .mem_err         (mem_err)
`endif
  );

  function automatic logic obs_err();
`ifdef MEM_RESPONDER_ERR_EN
    return mem_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    for (int i = 0; i < 4; i++)
      if (b[i]) model[a[AW+1:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  // Drives one request at a negedge (cycle 0), waits a bounded number of
  // cycles for mem_resp, then drops the request. lat = -1 on timeout.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         output int lat, output logic [31:0] rd_o, output logic err_o);
    @(negedge clk);
    mem_write = wr; mem_read = rd; mem_address = a; mem_wdata = d; mem_byte_enable = b;
    lat = -1; rd_o = 32'h0; err_o = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat = c; rd_o = mem_rdata; err_o = obs_err();
        break;
      end
    end
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    int lat; logic [31:0] r; logic e;
    run_txn(1'b1, 1'b0, a, d, 4'hF, lat, r, e);
    model_write(a, d, 4'hF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", mem_resp); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", mem_rdata); end
`ifdef MEM_RESPONDER_ERR_EN
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", mem_err); end
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] r, exp; logic e;
    run_txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, lat, r, e);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (lat != L) begin errors++; $display("FAIL wr_latency got=%0d exp=%0d", lat, L); end
    checks++; if (r !== last_rd) begin errors++; $display("FAIL wr_rdata_hold got=%h exp=%h", r, last_rd); end
    @(posedge clk); #1;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL resp_pulse_width got=%b exp=0", mem_resp); end
    exp_q.push_back(32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, r, e);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (lat != L) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", lat, L); end
    checks++; if (r !== exp) begin errors++; $display("FAIL rd_data got=%h exp=%h", r, exp); end
    last_rd = exp;
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] r, exp; logic e;
    preload(32'h20, 32'h11223344);
    run_txn(1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, lat, r, e);
    model_write(32'h20, 32'hAABBCCDD, 4'b0101);
    checks++; if (lat != L) begin errors++; $display("FAIL lane_wr_latency got=%0d exp=%0d", lat, L); end
    exp_q.push_back(32'h11BB33DD);
    run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, lat, r, e);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (r !== exp) begin errors++; $display("FAIL lane_rd_data got=%h exp=%h", r, exp); end
    last_rd = exp;
  endtask

  task automatic test_back_to_back();
    int n; int cyc [2]; logic [31:0] dat [2]; logic [31:0] exp;
    preload(32'h0, 32'h01010101);
    preload(32'h4, 32'h02020202);
    exp_q.push_back(model[0]);
    exp_q.push_back(model[1]);
    n = 0; cyc[0] = -1; cyc[1] = -1; dat[0] = 32'h0; dat[1] = 32'h0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h0;
    for (int c = 1; c <= 40 && n < 2; c++) begin
      @(posedge clk); #1;
      // First cycle after the first response: FSM back in IDLE, move to next word.
      if (n == 1 && mem_address != 32'h4) mem_address = 32'h4;
      if (mem_resp) begin
        cyc[n] = c; dat[n] = mem_rdata; n++;
      end
    end
    @(negedge clk);
    mem_read = 1'b0;
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", n); end
    checks++; if (cyc[0] != L) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc[0], L); end
    checks++; if (cyc[1] - cyc[0] != L + 1) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc[1] - cyc[0], L + 1); end
    for (int k = 0; k < 2; k++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      checks++; if (dat[k] !== exp) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", k, dat[k], exp); end
      last_rd = exp;
    end
  endtask

  task automatic test_abort();
    int lat; int resp_seen; logic [31:0] r, exp; logic e;
    preload(32'h30, 32'h0);
    @(negedge clk);
    mem_write = 1'b1; mem_address = 32'h30; mem_wdata = 32'h12345678; mem_byte_enable = 4'hF;
    @(negedge clk);
    mem_write = 1'b0;
    resp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (mem_resp) resp_seen++;
    end
    checks++; if (resp_seen != 0) begin errors++; $display("FAIL abort_resp got=%0d exp=0", resp_seen); end
    exp_q.push_back(model[8'h0C]);
    run_txn(1'b0, 1'b1, 32'h30, 32'h0, 4'h0, lat, r, e);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (lat != L) begin errors++; $display("FAIL abort_rd_latency got=%0d exp=%0d", lat, L); end
    checks++; if (r !== exp) begin errors++; $display("FAIL abort_rd_data got=%h exp=%h", r, exp); end
    last_rd = exp;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] r, exp; logic e;
    run_txn(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 4'hF, lat, r, e);
    checks++; if (lat != L) begin errors++; $display("FAIL wrap_wr_latency got=%0d exp=%0d", lat, L); end
`ifdef MEM_RESPONDER_ERR_EN
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL wrap_wr_err got=%b exp=1", e); end
`else
    model_write(32'h400, 32'hCAFEF00D, 4'hF);
`endif
    exp_q.push_back(model[0]);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, lat, r, e);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (r !== exp) begin errors++; $display("FAIL wrap_rd_data got=%h exp=%h", r, exp); end
`ifdef MEM_RESPONDER_ERR_EN
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wrap_rd_err got=%b exp=0", e); end
`endif
    last_rd = exp;
  endtask

  task automatic test_rw_both();
    int lat; logic [31:0] r, exp; logic e;
    preload(32'h50, 32'h0);
    run_txn(1'b1, 1'b1, 32'h50, 32'hA5A5A5A5, 4'hF, lat, r, e);
    checks++; if (lat != L) begin errors++; $display("FAIL rw_latency got=%0d exp=%0d", lat, L); end
    checks++; if (r !== last_rd) begin errors++; $display("FAIL rw_rdata_hold got=%h exp=%h", r, last_rd); end
`ifdef MEM_RESPONDER_ERR_EN
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rw_err got=%b exp=1", e); end
`else
    model_write(32'h50, 32'hA5A5A5A5, 4'hF);
`endif
    exp_q.push_back(model[8'h14]);
    run_txn(1'b0, 1'b1, 32'h50, 32'h0, 4'h0, lat, r, e);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (r !== exp) begin errors++; $display("FAIL rw_rd_data got=%h exp=%h", r, exp); end
    last_rd = exp;
  endtask

  task automatic test_be_zero();
    int lat; logic [31:0] r, exp; logic e;
    preload(32'h60, 32'h0BADF00D);
    run_txn(1'b1, 1'b0, 32'h60, 32'hFFFFFFFF, 4'h0, lat, r, e);
    model_write(32'h60, 32'hFFFFFFFF, 4'h0);
    checks++; if (lat != L) begin errors++; $display("FAIL be0_latency got=%0d exp=%0d", lat, L); end
    exp_q.push_back(model[8'h18]);
    run_txn(1'b0, 1'b1, 32'h60, 32'h0, 4'h0, lat, r, e);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (r !== exp) begin errors++; $display("FAIL be0_rd_data got=%h exp=%h", r, exp); end
    last_rd = exp;
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] r, exp; logic e;
    @(negedge clk);
    mem_write = 1'b1; mem_address = 32'h10; mem_wdata = 32'h55555555; mem_byte_enable = 4'hF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL midop_resp got=%b exp=0", mem_resp); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL midop_rdata got=%h exp=00000000", mem_rdata); end
    @(negedge clk); @(negedge clk);
    mem_write = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(model[8'h04]);
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, r, e);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (lat != L) begin errors++; $display("FAIL midop_rd_latency got=%0d exp=%0d", lat, L); end
    checks++; if (r !== exp) begin errors++; $display("FAIL midop_rd_data got=%h exp=%h", r, exp); end
    last_rd = exp;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    last_rd = 32'h0;
    #1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_rw_both();
    test_be_zero();
    test_reset_midop();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
